// File: rtl/anton_neopixel_stream.sv
// anton_neopixel_stream
// Serialises LED bytes from the pixel buffer onto the WS2812 single-wire line.
// Runs entirely in the 6.4 MHz domain: one WS2812 bit = 8 clocks (1.25 us).
//
// Ports:
//   clk6_4mhz  in   sole clock (6.4 MHz)
//   resetn     in   asynchronous active-low reset
//   syncStart  in   level request to start a frame, sampled only in IDLE
//   bufAddr    out  byte address to the pixel buffer synchronous read port
//   bufData    in   buffer read data, valid one clock after bufAddr changes
//   neoData    out  WS2812 serial output (straight from a flop)
//   neoState   out  FSM state code: IDLE=0 LOAD=1 SEND=2 RESET=3
//   busy       out  high in any state other than IDLE
//   frameDone  out  one-clock pulse in the first IDLE clock after RESET
module anton_neopixel_stream #(
  parameter int BUFFER_END   = 59,
  parameter int RESET_CYCLES = 320
) (
  input  logic        clk6_4mhz,
  input  logic        resetn,
  input  logic        syncStart,
  output logic [13:0] bufAddr,
  input  logic [7:0]  bufData,
  output logic        neoData,
  output logic [1:0]  neoState,
  output logic        busy,
  output logic        frameDone
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SEND  = 2'd2,
    S_RESET = 2'd3
  } state_t;

  localparam int              RW        = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [13:0]     LAST_BYTE = 14'(BUFFER_END);
  localparam logic [RW-1:0]   RC_LAST   = RW'(RESET_CYCLES - 1);

  state_t        state_q, state_d;
  logic [13:0]   addr_q, addr_d;     // read address, runs one byte ahead of byte_q
  logic [13:0]   byte_q, byte_d;     // index of the byte being shifted out
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    phase_q, phase_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    pref_q, pref_d;
  logic          neo_q, neo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // High portion of a bit cell: 5 clocks for '1', 2 clocks for '0'.
  function automatic logic bit_high(input logic b, input logic [2:0] ph);
    return b ? (ph < 3'd5) : (ph < 3'd2);
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    rcnt_d  = rcnt_q;
    shift_d = shift_q;
    pref_d  = pref_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        addr_d = 14'd0;
        if (syncStart) state_d = S_LOAD;
      end
      S_LOAD: begin
        // Address 0 was already presented during IDLE, so byte 0 is on bufData now.
        shift_d = bufData;
        byte_d  = 14'd0;
        addr_d  = (LAST_BYTE != 14'd0) ? 14'd1 : 14'd0;
        bit_d   = 3'd7;
        phase_d = 3'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        phase_d = phase_q + 3'd1;
        // bufAddr moved to the next byte when this byte started; data lands one clock later.
        if (bit_q == 3'd7 && phase_q == 3'd1) pref_d = bufData;
        if (phase_q == 3'd7) begin
          bit_d = bit_q - 3'd1;
          if (bit_q == 3'd0) begin
            if (byte_q < LAST_BYTE) begin
              shift_d = pref_q;
              byte_d  = byte_q + 14'd1;
              // Saturate so the address never runs past the last byte.
              if (addr_q < LAST_BYTE) addr_d = addr_q + 14'd1;
            end else begin
              state_d = S_RESET;
              rcnt_d  = '0;
              addr_d  = 14'd0;
            end
          end
        end
      end
      S_RESET: begin
        addr_d = 14'd0;
        rcnt_d = rcnt_q + RW'(1);
        if (rcnt_q == RC_LAST) begin
          rcnt_d  = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Output computed from next-state values so the flop lines up with the state.
    neo_d  = (state_d == S_SEND) && bit_high(shift_d[bit_d], phase_d);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk6_4mhz or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= 14'd0;
      byte_q  <= 14'd0;
      bit_q   <= 3'd0;
      phase_q <= 3'd0;
      rcnt_q  <= '0;
      shift_q <= 8'd0;
      pref_q  <= 8'd0;
      neo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      rcnt_q  <= rcnt_d;
      shift_q <= shift_d;
      pref_q  <= pref_d;
      neo_q   <= neo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bufAddr   = addr_q;
  assign neoData   = neo_q;
  assign neoState  = state_q;
  assign busy      = busy_q;
  assign frameDone = done_q;

endmodule

// File: tb/tb_anton_neopixel_stream.sv
`timescale 1ns/1ps
module tb_anton_neopixel_stream;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] resetn, syncStart, neoData, busy, frameDone;
  logic [13:0]   bufAddr  [NI];
  logic [7:0]    bufData  [NI];
  logic [1:0]    neoState [NI];
  logic [7:0]    mem      [NI][512];

  // Instance 0: BUFFER_END=2, 1: BUFFER_END=0 (single byte), 2: BUFFER_END=300 with short latch.
  function automatic int be_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 0 : 300;
  endfunction
  function automatic int rc_of(input int k);
    return (k == 2) ? 1 : 320;
  endfunction

  genvar g;
  for (g = 0; g < NI; g++) begin : g_dut
    anton_neopixel_stream #(
      .BUFFER_END  ((g == 0) ? 2 : (g == 1) ? 0 : 300),
      .RESET_CYCLES((g == 2) ? 1 : 320)
    ) u_dut (
      .clk6_4mhz(clk),
      .resetn   (resetn[g]),
      .syncStart(syncStart[g]),
      .bufAddr  (bufAddr[g]),
      .bufData  (bufData[g]),
      .neoData  (neoData[g]),
      .neoState (neoState[g]),
      .busy     (busy[g]),
      .frameDone(frameDone[g])
    );
  end

  // Pixel buffer with one clock of read latency.
  always @(posedge clk)
    for (int k = 0; k < NI; k++) bufData[k] <= mem[k][bufAddr[k][8:0]];

  int vectors = 0;
  int miscompares = 0;

  task automatic fail(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    miscompares++;
    $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) fail(name, got, exp);
    else vectors++;
  endtask

  // Scoreboard: one record per expected frame, bytes in order in bq.
  typedef struct { int inst; int nbytes; int rcyc; bit chained; } frame_t;
  frame_t     fq[$];
  logic [7:0] bq[$];

  // Monitor: decodes neoData into bit cells and bytes as the DUT emits them.
  int         cyc = 0;
  bit         in_frame = 1'b0;
  int         act, fcnt, bidx, ph, nsend, exp_a;
  frame_t     cur;
  logic [7:0] win, gotb, expb;
  bit         badw, rst_bad;
  int         done_cyc [NI];

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (!resetn[k]) begin
        if (in_frame && act == k) begin
          // Aborted frame: drop its remaining expected bytes.
          for (int i = bidx; i < cur.nbytes; i++) if (bq.size() > 0) bq.delete(0);
          in_frame = 1'b0;
        end
      end else if (neoState[k] == 2'd1) begin
        if (fq.size() == 0) fail($sformatf("unexpected_load_i%0d", k), 32'd1, 32'd0);
        else begin
          cur = fq.pop_front();
          chk("frame_inst", k, cur.inst);
          if (cur.chained) chk("b2b_gap", cyc - done_cyc[k], 1);
          chk("load_out", {neoData[k], bufAddr[k]}, 0);
          in_frame = 1'b1; act = k; fcnt = 0; bidx = 0;
          win = '0; gotb = '0; badw = 1'b0; rst_bad = 1'b0;
        end
      end else if (in_frame && act == k) begin
        fcnt++;
        nsend = 64 * cur.nbytes;
        if (fcnt <= nsend) begin
          ph = (fcnt - 1) % 8;
          win[7-ph] = neoData[k];
          if (ph == 7) begin
            if (win == 8'hF8)      gotb = {gotb[6:0], 1'b1};
            else if (win == 8'hC0) gotb = {gotb[6:0], 1'b0};
            else                   badw = 1'b1;
            if ((fcnt - 1) % 64 == 63) begin
              expb = (bq.size() > 0) ? bq.pop_front() : 8'hxx;
              chk($sformatf("byte%0d_i%0d", bidx, k), {badw, gotb}, {1'b0, expb});
              exp_a = (bidx + 1 < be_of(k)) ? bidx + 1 : be_of(k);
              chk($sformatf("addr_byte%0d_i%0d", bidx, k), bufAddr[k], exp_a);
              bidx++;
              badw = 1'b0;
            end
          end
        end else if (fcnt <= nsend + cur.rcyc) begin
          if (neoData[k] || bufAddr[k] != 14'd0 || neoState[k] != 2'd3 || frameDone[k]) rst_bad = 1'b1;
        end else begin
          chk($sformatf("frameDone_at_%0d_i%0d", fcnt, k), frameDone[k], 1);
          chk("latch_low", rst_bad, 0);
          chk("idle_after", {busy[k], neoState[k]}, 0);
          done_cyc[k] = cyc;
          in_frame = 1'b0;
        end
      end
      if (frameDone[k] && done_cyc[k] != cyc) fail($sformatf("spurious_done_i%0d", k), 32'd1, 32'd0);
    end
  end

  task automatic fill(input int k, input bit ramp);
    for (int a = 0; a <= be_of(k); a++) mem[k][a] = ramp ? 8'(a) : 8'($urandom);
  endtask

  task automatic push_frame(input int k, input bit chained);
    frame_t f;
    f.inst = k; f.nbytes = be_of(k) + 1; f.rcyc = rc_of(k); f.chained = chained;
    fq.push_back(f);
    for (int a = 0; a <= be_of(k); a++) bq.push_back(mem[k][a]);
  endtask

  task automatic pulse(input int k);
    @(negedge clk) syncStart[k] = 1'b1;
    @(negedge clk) syncStart[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frameDone[k] && n < budget);
    if (!frameDone[k]) fail($sformatf("timeout_i%0d", k), n, budget);
  endtask

  initial begin
    resetn = '0;
    syncStart = '0;
    for (int k = 0; k < NI; k++) for (int a = 0; a < 512; a++) mem[k][a] = 8'h00;
    repeat (3) @(negedge clk);
    resetn = '1;

    // Idle after reset with no start request.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++)
        chk($sformatf("idle_i%0d", k), {neoData[k], busy[k], frameDone[k], neoState[k], bufAddr[k]}, 0);
    end

    // Single byte 0xA5, then random single bytes.
    mem[1][0] = 8'hA5;
    push_frame(1, 1'b0); pulse(1); wait_done(1, 1000);
    for (int r = 0; r < 3; r++) begin
      fill(1, 1'b0); push_frame(1, 1'b0); pulse(1); wait_done(1, 1000);
    end

    // Seamless bytes, then random triples.
    mem[0][0] = 8'hFF; mem[0][1] = 8'h00; mem[0][2] = 8'h80;
    push_frame(0, 1'b0); pulse(0); wait_done(0, 2000);
    for (int r = 0; r < 3; r++) begin
      fill(0, 1'b0); push_frame(0, 1'b0); pulse(0); wait_done(0, 2000);
    end

    // Back-to-back frames with syncStart held.
    fill(0, 1'b0); push_frame(0, 1'b0); push_frame(0, 1'b1);
    @(negedge clk) syncStart[0] = 1'b1;
    wait_done(0, 2000);
    @(negedge clk) syncStart[0] = 1'b0;
    wait_done(0, 2000);

    // Mid-frame reset during bit 3 of byte 1, then restart from byte 0.
    fill(0, 1'b0); push_frame(0, 1'b0); pulse(0);
    repeat (97) @(negedge clk);
    chk("bit_cell_phase0_high", neoData[0], 1);
    #1 resetn[0] = 1'b0;
    #1 chk("async_reset_out", {neoData[0], busy[0], neoState[0], bufAddr[0]}, 0);
    repeat (2) @(negedge clk);
    resetn[0] = 1'b1;
    fill(0, 1'b0); push_frame(0, 1'b0); pulse(0); wait_done(0, 2000);

    // Long buffer: bytes equal address low bits, address must saturate at the end.
    fill(2, 1'b1); push_frame(2, 1'b0); pulse(2); wait_done(2, 25000);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", fq.size() + bq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
